// File: rtl/calc_div_arbiter.sv
// Round-robin front end that shares a single multi-cycle divider between
// NREQ calculator requesters. Handles divide-by-zero locally and aborts a
// divide that runs past TIMEOUT cycles.
module calc_div_arbiter #(
  parameter  int BITS    = 32,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BITS-1:0]   req_dividend,
  input  logic [NREQ*16-1:0]     req_divisor,
  output logic [NREQ-1:0]        gnt,
  output logic                   div_start,
  output logic [BITS-1:0]        div_dividend,
  output logic signed [15:0]     div_divisor,
  input  logic                   div_done,
  input  logic [BITS-1:0]        div_quotient,
  input  logic [BITS-1:0]        div_remainder,
  output logic                   resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [BITS-1:0]        resp_quotient,
  output logic [BITS-1:0]        resp_remainder,
  output logic [1:0]             resp_err,
  output logic                   busy
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [IDW-1:0]        rr;
  logic [IDW-1:0]        rr_next;
  logic [IDW-1:0]        win;
  logic [IDW-1:0]        id_r;
  logic [CW-1:0]         cnt;
  logic [BITS-1:0]       sel_dividend;
  logic signed [15:0]    sel_divisor;
  logic                  found;
  int                    idx;
  logic                  timeout_hit;

  // Pick the first requester at or above the round-robin pointer (with wrap).
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    sel_dividend = req_dividend[int'(win)*BITS +: BITS];
    sel_divisor  = req_divisor[int'(win)*16 +: 16];
    rr_next      = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
    timeout_hit  = (cnt == CW'(TIMEOUT-1));
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and the single-cycle strobes.
  always_comb begin
    state_next = state;
    gnt        = '0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (found && !reset) begin
          gnt[win]   = 1'b1;
          state_next = (sel_divisor == 16'sd0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_start  = !reset;
        state_next = WAIT;
      end
      WAIT: begin
        if (div_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        resp_valid = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, timeout counting and response capture. Response
  // fields only change on entry to RESP so they stay stable afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr             <= '0;
      id_r           <= '0;
      cnt            <= '0;
      div_dividend   <= '0;
      div_divisor    <= '0;
      resp_id        <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_err       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            rr           <= rr_next;
            id_r         <= win;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            if (sel_divisor == 16'sd0) begin
              resp_id        <= win;
              resp_quotient  <= '1;
              resp_remainder <= sel_dividend;
              resp_err       <= 2'b01;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (div_done) begin
            resp_id        <= id_r;
            resp_quotient  <= div_quotient;
            resp_remainder <= div_remainder;
            resp_err       <= 2'b00;
          end else if (timeout_hit) begin
            resp_id        <= id_r;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_err       <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_div_arbiter.sv
// Directed bench for calc_div_arbiter: a cycle-indexed transaction model
// predicts grant/start/response timing and results, with a mock divider.
module tb_calc_div_arbiter;

  localparam int BITS    = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*BITS-1:0] req_dividend = '0;
  logic [NREQ*16-1:0]   req_divisor = '0;
  logic [NREQ-1:0]      gnt;
  logic                 div_start;
  logic [BITS-1:0]      div_dividend;
  logic [15:0]          div_divisor;
  logic                 div_done = 1'b0;
  logic [BITS-1:0]      div_quotient = '0;
  logic [BITS-1:0]      div_remainder = '0;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [BITS-1:0]      resp_quotient;
  logic [BITS-1:0]      resp_remainder;
  logic [1:0]           resp_err;
  logic                 busy;

  calc_div_arbiter #(.BITS(BITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .gnt(gnt), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_quotient(resp_quotient),
    .resp_remainder(resp_remainder), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model state (transaction timeline, not the DUT's FSM)
  int              mock_delay = 3;   // divider busy cycles after start, done next; <0 = never
  int              extra_done = -1;  // one stray done pulse at this cycle
  int              done_at = -1;
  int              rr_m = 0;
  int              gnt_c = -10, start_c = -10, resp_c = -10;
  logic [BITS-1:0] p_q, p_r, p_a, e_q = '0, e_r = '0;
  logic [15:0]     p_b;
  logic [1:0]      p_err, e_err = 2'b00;
  int              p_id, e_id = 0;

  // Observations for literal checks
  int              glog[$];
  int              obs_gnt_c = -1, obs_resp_c = -1;
  int              start_count = 0, resp_count = 0;
  logic [BITS-1:0] l_q, l_r;
  logic [1:0]      l_err;
  int              l_id;

  // Model step, per-cycle compare, and mock divider.
  always @(negedge clk) begin
    logic [NREQ-1:0] e_gnt;
    logic            e_rv, e_busy;
    int              w;
    if (reset) begin
      rr_m = 0; gnt_c = -10; start_c = -10; resp_c = -10;
      e_id = 0; e_q = '0; e_r = '0; e_err = 2'b00;
      done_at = -1; div_done = 1'b0;
    end else begin
      e_gnt = '0;
      if (cyc > resp_c && req != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
        e_gnt[w] = 1'b1;
        rr_m  = (w + 1) % NREQ;
        p_a   = req_dividend[w*BITS +: BITS];
        p_b   = req_divisor[w*16 +: 16];
        p_id  = w;
        gnt_c = cyc;
        if (p_b == 16'd0) begin
          start_c = -10; resp_c = cyc + 1;
          p_q = '1; p_r = p_a; p_err = 2'b01;
        end else begin
          start_c = cyc + 1;
          if (mock_delay >= 0 && mock_delay + 1 <= TIMEOUT) begin
            resp_c = start_c + mock_delay + 2;
            p_q = p_a / {16'd0, p_b}; p_r = p_a % {16'd0, p_b}; p_err = 2'b00;
          end else begin
            resp_c = start_c + TIMEOUT + 1;
            p_q = '0; p_r = '0; p_err = 2'b10;
          end
        end
      end
      e_rv = (cyc == resp_c);
      if (e_rv) begin
        e_id = p_id; e_q = p_q; e_r = p_r; e_err = p_err;
      end
      e_busy = (cyc > gnt_c) && (cyc <= resp_c);

      chk("gnt", gnt, e_gnt);
      chk("div_start", div_start, cyc == start_c);
      chk("resp_valid", resp_valid, e_rv);
      chk("busy", busy, e_busy);
      chk("resp_id", resp_id, e_id);
      chk("resp_quotient", resp_quotient, e_q);
      chk("resp_remainder", resp_remainder, e_r);
      chk("resp_err", resp_err, e_err);
      if (cyc == start_c) begin
        chk("div_dividend", div_dividend, p_a);
        chk("div_divisor", div_divisor, p_b);
      end

      for (int j = 0; j < NREQ; j++)
        if (gnt[j]) begin glog.push_back(j); obs_gnt_c = cyc; end
      if (div_start) start_count++;
      if (resp_valid) begin
        resp_count++; obs_resp_c = cyc;
        l_q = resp_quotient; l_r = resp_remainder; l_err = resp_err; l_id = resp_id;
      end

      if (div_start && mock_delay >= 0) begin
        done_at       = cyc + mock_delay + 1;
        div_quotient  = div_dividend / {16'd0, div_divisor};
        div_remainder = div_dividend % {16'd0, div_divisor};
      end
      div_done = (cyc == done_at) || (cyc == extra_done);
    end
  end

  task automatic set_slot(input int i, input logic [BITS-1:0] a, input logic [15:0] b);
    req_dividend[i*BITS +: BITS] = a;
    req_divisor[i*16 +: 16] = b;
  endtask

  task automatic grant_and_drop(input logic [NREQ-1:0] mask, output int w);
    req = mask; w = -1;
    for (int i = 0; i < 50 && w < 0; i++) begin
      @(negedge clk);
      for (int j = 0; j < NREQ; j++) if (gnt[j]) w = j;
    end
    chk("gnt_seen", w >= 0, 1'b1);
    @(posedge clk); #1;
    if (w >= 0) req[w] = 1'b0;
  endtask

  task automatic wait_resp();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("resp_seen", seen, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s0, r0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Single request: 100 / 7 with a 34-cycle divider
    mock_delay = 34;
    set_slot(0, 100, 7);
    grant_and_drop(4'b0001, w);
    wait_resp();
    chk("single_latency", obs_resp_c - obs_gnt_c, 37);
    chk("single_id", l_id, 0);
    chk("single_q", l_q, 14);
    chk("single_r", l_r, 2);
    chk("single_err", l_err, 2'b00);

    // Round robin with all four requesting
    mock_delay = 3;
    for (int i = 0; i < NREQ; i++) set_slot(i, 1000 + i*17, 16'(i + 3));
    glog.delete();
    for (int n = 0; n < 5; n++) begin
      grant_and_drop(4'b1111, w);
      wait_resp();
    end
    req = '0;
    chk("rr_len", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("rr_0", glog[0], 1);  // pointer sits at 1 after the single test
      chk("rr_1", glog[1], 2);
      chk("rr_2", glog[2], 3);
      chk("rr_3", glog[3], 0);
      chk("rr_4", glog[4], 1);
    end

    // Divide by zero on requester 2
    set_slot(2, 32'h1234, 16'h0000);
    s0 = start_count;
    grant_and_drop(4'b0100, w);
    @(posedge clk); #1;
    chk("dz_latency", obs_resp_c - obs_gnt_c, 1);
    chk("dz_id", l_id, 2);
    chk("dz_q", l_q, 32'hFFFF_FFFF);
    chk("dz_r", l_r, 32'h1234);
    chk("dz_err", l_err, 2'b01);
    chk("dz_no_start", start_count - s0, 0);

    // Timeout: divider never answers, then a normal request
    mock_delay = -1;
    set_slot(3, 555, 5);
    grant_and_drop(4'b1000, w);
    wait_resp();
    chk("to_latency", obs_resp_c - obs_gnt_c, 66);
    chk("to_err", l_err, 2'b10);
    chk("to_q", l_q, 0);
    chk("to_r", l_r, 0);
    mock_delay = 5;
    set_slot(0, 77, 4);
    grant_and_drop(4'b0001, w);
    wait_resp();
    chk("after_to_err", l_err, 2'b00);
    chk("after_to_q", l_q, 19);

    // Done arriving on the final timeout cycle wins
    mock_delay = TIMEOUT - 1;
    set_slot(1, 1000, 3);
    grant_and_drop(4'b0010, w);
    wait_resp();
    chk("coll_err", l_err, 2'b00);
    chk("coll_q", l_q, 333);
    chk("coll_r", l_r, 1);

    // Reset in the middle of WAIT
    mock_delay = -1;
    set_slot(1, 500, 9);
    grant_and_drop(4'b0010, w);
    for (int i = 0; i < 20 && !div_start; i++) @(negedge clk);
    r0 = resp_count;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    extra_done = cyc + 2;
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("rst_no_resp", resp_count - r0, 0);
    mock_delay = 2;
    set_slot(1, 90, 9);
    set_slot(2, 90, 9);
    grant_and_drop(4'b0110, w);
    chk("rst_rr_winner", w, 1);
    wait_resp();
    chk("rst_after_q", l_q, 10);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
